// File: rtl/mac_operand_feeder.sv
// Feeds mac_16: walks A tiles (16 banks read in parallel) and B rows, one B row per beat.
// Read issue to vec_valid is 2 cycles; hold freezes issue, counters and outputs, keeping any in-flight read pending.
module mac_operand_feeder #(
  parameter int ROW_W      = 264,
  parameter int NUM_BANKS  = 16,
  parameter int B_PER_TILE = 16,
  parameter int NUM_TILES  = 128,
  parameter int ADDR_W     = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          cfg_int8,
  input  logic                          cfg_int4,
  input  logic                          cfg_vsq,
  input  logic                          hold,
  output logic                          a_rd_en,
  output logic [ADDR_W-1:0]             a_rd_addr,
  input  logic [NUM_BANKS*ROW_W-1:0]    a_rd_data,
  output logic                          b_rd_en,
  output logic [ADDR_W-1:0]             b_rd_addr,
  input  logic [ROW_W-1:0]              b_rd_data,
  output logic [NUM_BANKS*ROW_W-1:0]    a_vec,
  output logic [ROW_W-1:0]              b_vec,
  output logic                          vec_valid,
  output logic                          tile_first,
  output logic                          is_int8_mode,
  output logic                          is_int4_mode,
  output logic                          is_vsq,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int BEAT_W = (B_PER_TILE > 1) ? $clog2(B_PER_TILE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [TILE_W-1:0]   r_tile;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_pend;
  logic                r_pend_a;

  logic w_cfg_bad;
  logic w_accept;
  logic w_last_beat;
  logic w_last;
  logic w_issue;
  logic w_capture;

  assign w_cfg_bad   = cfg_int8 & cfg_int4;
  assign w_accept    = (r_state == S_IDLE) & start & ~w_cfg_bad;
  assign w_last_beat = (r_beat == BEAT_W'(B_PER_TILE - 1));
  assign w_last      = w_last_beat & (r_tile == TILE_W'(NUM_TILES - 1));
  assign w_issue     = (r_state == S_RUN) & ~hold;
  // A pending read is captured on any un-held cycle of RUN or DRAIN.
  assign w_capture   = (r_state != S_IDLE) & ~hold & r_pend;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (!hold && w_last) w_next = S_DRAIN;
      S_DRAIN: if (!hold && !r_pend) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    a_rd_en   = w_issue & (r_beat == '0);
    b_rd_en   = w_issue;
    busy      = (r_state != S_IDLE);
    a_rd_addr = ADDR_W'(r_tile);
    b_rd_addr = ADDR_W'(r_tile) * ADDR_W'(B_PER_TILE) + ADDR_W'(r_beat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tile   <= '0;
      r_beat   <= '0;
      r_pend   <= 1'b0;
      r_pend_a <= 1'b0;
    end else if (w_accept) begin
      r_tile   <= '0;
      r_beat   <= '0;
      r_pend   <= 1'b0;
      r_pend_a <= 1'b0;
    end else if (w_issue) begin
      r_pend   <= 1'b1;
      r_pend_a <= (r_beat == '0);
      if (w_last_beat) begin
        r_beat <= '0;
        r_tile <= (r_tile == TILE_W'(NUM_TILES - 1)) ? '0 : r_tile + 1'b1;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end else if (w_capture) begin
      r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vec        <= '0;
      b_vec        <= '0;
      vec_valid    <= 1'b0;
      tile_first   <= 1'b0;
      is_int8_mode <= 1'b0;
      is_int4_mode <= 1'b0;
      is_vsq       <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      vec_valid  <= w_capture;
      tile_first <= w_capture & r_pend_a;
      done       <= (r_state == S_DRAIN) & ~hold & ~r_pend;
      cfg_err    <= (r_state == S_IDLE) & start & w_cfg_bad;
      if (w_accept) begin
        is_int8_mode <= cfg_int8;
        is_int4_mode <= cfg_int4;
        is_vsq       <= cfg_vsq;
      end
      if (w_capture) begin
        b_vec <= b_rd_data;
        // The A SRAM only re-reads on beat 0, so a_vec stays put for the rest of the tile.
        if (r_pend_a) a_vec <= a_rd_data;
      end
    end
  end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Upstream stage of mac_16.
- Sequences reads from the A operand SRAM (16 banks, read in parallel) and the B operand SRAM (single bank). Drives a_vec, b_vec and the mode bits into mac_16, one B row per beat.
- Replaces the hand-written stimulus loop. A new A tile is presented on the first beat of each group of B_PER_TILE beats, and the same A tile is held for the rest of the group.

Parameters:
ROW_W, 264, width of one SRAM row / operand vector
NUM_BANKS, 16, A banks and rows per A tile
B_PER_TILE, 16, B beats per A tile
NUM_TILES, 128, A tiles per job
ADDR_W, 11, SRAM address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle job request, sampled only in IDLE
cfg_int8  in  1  int8 mode request, latched at accepted start
cfg_int4  in  1  int4 mode request, latched at accepted start
cfg_vsq  in  1  VSQ request, latched at accepted start
hold  in  1  backpressure: freeze beat issue and output registers
a_rd_en  out  1  A SRAM read enable (all banks)
a_rd_addr  out  ADDR_W  A bank address = tile index
a_rd_data  in  NUM_BANKS*ROW_W  bank k on bits [k*ROW_W +: ROW_W]; 1-cycle latency; holds last value while a_rd_en=0
b_rd_en  out  1  B SRAM read enable
b_rd_addr  out  ADDR_W  B address = tile*B_PER_TILE + beat
b_rd_data  in  ROW_W  1-cycle latency; holds last value while b_rd_en=0
a_vec  out  NUM_BANKS*ROW_W  to mac_16 a_vec
b_vec  out  ROW_W  to mac_16 b_vec
vec_valid  out  1  a_vec/b_vec carry a new beat this cycle
tile_first  out  1  beat 0 of a tile (a_vec just updated)
is_int8_mode, is_int4_mode, is_vsq  out  1 each  latched mode bits to mac_16
busy  out  1  job in progress
done  out  1  one-cycle pulse after the last beat is presented
cfg_err  out  1  one-cycle pulse: start rejected because cfg_int8 and cfg_int4 were both 1

Behaviour:
- Reset (rst=1 at a clk edge) drives every output to 0, including a_vec, b_vec, the addresses and the mode bits. State goes to IDLE and counters clear. This applies from any state, mid-job included; any in-flight read is discarded.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with a legal config: latch the mode bits, clear tile and beat counters, go to RUN, busy=1 next cycle.
  - start=1 with cfg_int8 & cfg_int4 both 1: cfg_err pulses next cycle, stay in IDLE, mode bits unchanged.
  - start while busy is ignored.
- RUN, each cycle with hold=0:
  - Issue b_rd_en=1 with b_rd_addr = tile*B_PER_TILE + beat.
  - If beat==0, also issue a_rd_en=1 with a_rd_addr = tile.
  - Capture the previous cycle's read, if any, into the output registers.
  - Advance beat. Beat wraps at B_PER_TILE-1 to 0 and tile increments.
  - After issuing tile NUM_TILES-1, beat B_PER_TILE-1, go to DRAIN.
- Capture:
  - b_vec <= b_rd_data.
  - a_vec <= a_rd_data only for beat-0 reads; otherwise a_vec holds.
  - vec_valid=1 and tile_first = (captured beat == 0).
- DRAIN (hold=0): capture the final read, then go to IDLE. done and busy=0 take effect the cycle after the final vec_valid.
- hold=1 (RUN or DRAIN):
  - No read is issued: rd_en=0.
  - Output registers, counters and state freeze; vec_valid=0.
  - A read already in flight is kept pending; the SRAM output holds its data.
  - The pending read is captured on the first cycle hold=0, while the next read is issued that same cycle.
- Latency: start sampled at edge 0 gives first read at edge 1 and beat n vec_valid at edge n+2. With no hold, the last beat (2047) is valid at edge 2049 and done at edge 2050.
- a_vec, b_vec and the mode bits keep their last values after done; mac_16 latches its own results.
- rd_en is never asserted outside RUN.

Test Plan:
- Reset mid-job: start, then rst=1 at edge 500 -> all outputs 0 next cycle, state IDLE, no further rd_en.
- Nominal int8 job: start with cfg_int8=1 and pattern SRAMs loaded. Required:
  - 2048 vec_valid beats at edges 2..2049, done pulse at edge 2050.
  - b_rd_addr sequence 0..2047; a_rd_addr 0..127, each issued once, on beats with beat==0.
  - mac_16 latch_array_out equals the golden output file.
- Beat content: at beat 37 (tile 2, beat 5) b_vec = B row 37 and a_vec bank k = A row 32+k; tile_first=0. At beat 32, tile_first=1.
- Hold: hold=1 for 3 cycles starting at edge 10, then again on the cycle of a tile boundary -> vec_valid gaps of exactly 3 and 1 cycles, no beat skipped or duplicated, done delayed by 4 cycles.
- Config error: start with cfg_int8=cfg_int4=1 -> cfg_err pulse, busy stays 0, no reads. A later legal start runs normally.
- Start while busy: start pulses at edges 5 and 1000 -> ignored, beat sequence unchanged, single done pulse.
